// File: rtl/regfile_writeback.sv
// Purpose: in-order writeback queue that arbitrates ALU and load results and drives the register file write port from flops.
// Latency: a result accepted at edge k into an empty queue with wbStall low is written at edge k+1 (regWrite high k+1..k+2), 1 write/cycle.
// Backpressure: both readies drop when the registered count shows the queue full; wbStall freezes retirement without losing entries.
module regfile_writeback #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int NUM_REGS   = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  aluValid,
    output logic                  aluReady,
    input  logic [ADDR_WIDTH-1:0] aluRd,
    input  logic [DATA_WIDTH-1:0] aluData,
    input  logic                  memValid,
    output logic                  memReady,
    input  logic [ADDR_WIDTH-1:0] memRd,
    input  logic [DATA_WIDTH-1:0] memData,
    input  logic                  wbStall,
    output logic [ADDR_WIDTH-1:0] writeRegister,
    output logic [DATA_WIDTH-1:0] writeData,
    output logic                  regWrite,
    output logic [NUM_REGS-1:0]   pendingMask
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [NUM_REGS-1:0] REG_ONE = NUM_REGS'(1);

    typedef enum logic {SRC_MEM = 1'b0, SRC_ALU = 1'b1} src_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] rd;
        logic [DATA_WIDTH-1:0] data;
    } wbEntry_t;

    wbEntry_t              queue [FIFO_DEPTH];
    logic [PTR_W-1:0]      headPtr;
    logic [PTR_W-1:0]      tailPtr;
    logic [PTR_W:0]        count;
    src_t                  rr;
    logic                  full;
    logic                  aluFire;
    logic                  memFire;
    logic                  push;
    logic                  pop;
    wbEntry_t              pushEntry;
    wbEntry_t              headEntry;
    logic [FIFO_DEPTH-1:0] slotLive;

    // Register 0 is hardwired and addresses past the register file are dropped at retirement.
    function automatic logic rdValid(input logic [ADDR_WIDTH-1:0] rd);
        return (rd != '0) && ({{(32-ADDR_WIDTH){1'b0}}, rd} < 32'(NUM_REGS));
    endfunction

    // Full uses the registered count only, so a same-cycle pop never opens a slot.
    assign full      = (count == DEPTH_CNT);
    assign aluReady  = !full && (!memValid || rr == SRC_ALU);
    assign memReady  = !full && (!aluValid || rr == SRC_MEM);
    assign aluFire   = aluValid && aluReady;
    assign memFire   = memValid && memReady;
    assign push      = aluFire || memFire;
    assign pushEntry = aluFire ? '{rd: aluRd, data: aluData} : '{rd: memRd, data: memData};
    assign pop       = !wbStall && (count != '0);
    assign headEntry = queue[headPtr];

    // A slot holds a live entry when its distance from the head is below the count.
    for (genvar g = 0; g < FIFO_DEPTH; g++) begin : gSlot
        logic [PTR_W-1:0] offset;
        assign offset      = PTR_W'(g) - headPtr;
        assign slotLive[g] = ({1'b0, offset} < count);
    end

    // Queue payload storage; validity lives in the pointers and count, so no reset is needed here.
    always_ff @(posedge clock) begin
        if (push) begin
            queue[tailPtr] <= pushEntry;
        end
    end

    // Queue pointers, occupancy and round-robin state.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            rr      <= SRC_MEM;
        end else begin
            if (push) tailPtr <= tailPtr + PTR_W'(1);
            if (pop)  headPtr <= headPtr + PTR_W'(1);
            if (push && !pop)      count <= count + (PTR_W+1)'(1);
            else if (pop && !push) count <= count - (PTR_W+1)'(1);
            if (aluFire)      rr <= SRC_MEM;
            else if (memFire) rr <= SRC_ALU;
        end
    end

    // Register file port: every pop loads the head, only in-range non-zero targets assert the strobe.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            writeRegister <= '0;
            writeData     <= '0;
            regWrite      <= 1'b0;
        end else if (pop) begin
            writeRegister <= headEntry.rd;
            writeData     <= headEntry.data;
            regWrite      <= rdValid(headEntry.rd);
        end else begin
            regWrite      <= 1'b0;
        end
    end

    // Hazard mask: every live queued write plus the write currently on the port.
    always_comb begin
        pendingMask = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (slotLive[i] && rdValid(queue[i].rd)) begin
                pendingMask = pendingMask | (REG_ONE << queue[i].rd);
            end
        end
        if (regWrite) begin
            pendingMask = pendingMask | (REG_ONE << writeRegister);
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Purpose: directed bench for regfile_writeback with a per-cycle vector table and hand-written stall/reset sequences.
// Latency: checks readies and registered outputs 1 time unit after each falling edge.
// Backpressure: exercises full-queue stall, release, and reset with queued entries.
module tb_regfile_writeback;

    logic        clock;
    logic        resetN;
    logic        aluValid;
    logic        aluReady;
    logic [5:0]  aluRd;
    logic [31:0] aluData;
    logic        memValid;
    logic        memReady;
    logic [5:0]  memRd;
    logic [31:0] memData;
    logic        wbStall;
    logic [5:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic [31:0] pendingMask;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic        aV;
        logic [5:0]  aRd;
        logic [31:0] aD;
        logic        mV;
        logic [5:0]  mRd;
        logic [31:0] mD;
        logic        stall;
        logic        eAR;
        logic        eMR;
        logic        eRW;
        logic [5:0]  eWR;
        logic [31:0] eWD;
        logic [31:0] eMask;
    } vec_t;

    vec_t vecs[$];

    regfile_writeback #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(32), .FIFO_DEPTH(4)
    ) dut (
        .clock(clock), .resetN(resetN),
        .aluValid(aluValid), .aluReady(aluReady), .aluRd(aluRd), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memRd(memRd), .memData(memData),
        .wbStall(wbStall),
        .writeRegister(writeRegister), .writeData(writeData), .regWrite(regWrite),
        .pendingMask(pendingMask)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic vec_t mk(input logic aV, input logic [5:0] aRd, input logic [31:0] aD,
                                input logic mV, input logic [5:0] mRd, input logic [31:0] mD,
                                input logic stall, input logic eAR, input logic eMR, input logic eRW,
                                input logic [5:0] eWR, input logic [31:0] eWD, input logic [31:0] eMask);
        vec_t v;
        v = '{aV, aRd, aD, mV, mRd, mD, stall, eAR, eMR, eRW, eWR, eWD, eMask};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic aV, input logic [5:0] aRd, input logic [31:0] aD,
                         input logic mV, input logic [5:0] mRd, input logic [31:0] mD,
                         input logic stall);
        aluValid = aV; aluRd = aRd; aluData = aD;
        memValid = mV; memRd = mRd; memData = mD;
        wbStall  = stall;
    endtask

    task automatic chkPort(input string tag, input logic eRW, input logic [5:0] eWR, input logic [31:0] eWD);
        chk({tag, " regWrite"}, 32'(regWrite), 32'(eRW));
        chk({tag, " writeRegister"}, 32'(writeRegister), 32'(eWR));
        chk({tag, " writeData"}, writeData, eWD);
    endtask

    initial begin
        // single ALU write
        vecs.push_back(mk(1, 5, 32'h12345678, 0, 0, 0, 0,  1, 1, 0, 0, 32'h0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 0, 0, 32'h0, 32'h20));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 1, 5, 32'h12345678, 32'h20));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 0, 5, 32'h12345678, 32'h0));
        // same-register ordering: mem rd7 A then alu rd7 B
        vecs.push_back(mk(0, 0, 0, 1, 7, 32'hA, 0,         0, 1, 0, 5, 32'h12345678, 32'h0));
        vecs.push_back(mk(1, 7, 32'hB, 0, 0, 0, 0,         1, 0, 0, 5, 32'h12345678, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 1, 7, 32'hA, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 1, 7, 32'hB, 32'h80));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 0, 7, 32'hB, 32'h0));
        // contention: alu 1,2,3 vs mem 10,11,12, grants MEM first
        vecs.push_back(mk(1, 1, 32'h101, 1, 10, 32'h20A, 0, 0, 1, 0, 7, 32'hB, 32'h0));
        vecs.push_back(mk(1, 1, 32'h101, 1, 11, 32'h20B, 0, 1, 0, 0, 7, 32'hB, 32'h400));
        vecs.push_back(mk(1, 2, 32'h102, 1, 11, 32'h20B, 0, 0, 1, 1, 10, 32'h20A, 32'h402));
        vecs.push_back(mk(1, 2, 32'h102, 1, 12, 32'h20C, 0, 1, 0, 1, 1, 32'h101, 32'h802));
        vecs.push_back(mk(1, 3, 32'h103, 1, 12, 32'h20C, 0, 0, 1, 1, 11, 32'h20B, 32'h804));
        vecs.push_back(mk(1, 3, 32'h103, 0, 0, 0, 0,       1, 0, 1, 2, 32'h102, 32'h1004));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 1, 12, 32'h20C, 32'h1008));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 1, 3, 32'h103, 32'h8));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 0, 3, 32'h103, 32'h0));
        // invalid targets: rd0 then rd40
        vecs.push_back(mk(1, 0, 32'hFFFFFFFF, 0, 0, 0, 0,  1, 1, 0, 3, 32'h103, 32'h0));
        vecs.push_back(mk(0, 0, 0, 1, 40, 32'h55, 0,       0, 1, 0, 3, 32'h103, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 0, 0, 32'hFFFFFFFF, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0,             1, 1, 0, 40, 32'h55, 32'h0));

        resetN = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        #2;
        chkPort("reset", 0, 0, 32'h0);
        chk("reset pendingMask", pendingMask, 32'h0);
        chk("reset aluReady", 32'(aluReady), 32'd1);
        chk("reset memReady", 32'(memReady), 32'd1);
        @(negedge clock);
        resetN = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            @(negedge clock);
            drive(vecs[i].aV, vecs[i].aRd, vecs[i].aD, vecs[i].mV, vecs[i].mRd, vecs[i].mD, vecs[i].stall);
            #1;
            tag = $sformatf("v%0d", i);
            chk({tag, " aluReady"}, 32'(aluReady), 32'(vecs[i].eAR));
            chk({tag, " memReady"}, 32'(memReady), 32'(vecs[i].eMR));
            chkPort(tag, vecs[i].eRW, vecs[i].eWR, vecs[i].eWD);
            chk({tag, " pendingMask"}, pendingMask, vecs[i].eMask);
        end

        // backpressure: stalled stream of 5 ALU writes fills the 4-entry queue
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            drive(1, 6'(k), 32'h300 + 32'(k), 0, 0, 0, 1);
            #1;
            chk($sformatf("bp fill%0d aluReady", k), 32'(aluReady), (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("bp fill%0d regWrite", k), 32'(regWrite), 32'd0);
        end
        chk("bp full pendingMask", pendingMask, 32'h1E);
        @(negedge clock);
        drive(1, 5, 32'h305, 0, 0, 0, 0);
        #1;
        chk("bp release aluReady", 32'(aluReady), 32'd0);
        chk("bp release regWrite", 32'(regWrite), 32'd0);
        @(negedge clock);
        #1;
        chk("bp accept5 aluReady", 32'(aluReady), 32'd1);
        chkPort("bp wr1", 1, 6'd1, 32'h301);
        for (int k = 2; k <= 5; k++) begin
            @(negedge clock);
            drive(0, 0, 0, 0, 0, 0, 0);
            #1;
            chkPort($sformatf("bp wr%0d", k), 1, 6'(k), 32'h300 + 32'(k));
        end
        @(negedge clock);
        #1;
        chk("bp drained regWrite", 32'(regWrite), 32'd0);
        chk("bp drained pendingMask", pendingMask, 32'h0);

        // reset mid-stream: 3 entries queued and a write on the port
        for (int k = 6; k <= 8; k++) begin
            @(negedge clock);
            drive(1, 6'(k), 32'h400 + 32'(k), 0, 0, 0, 1);
            #1;
            chk($sformatf("rst fill%0d aluReady", k), 32'(aluReady), 32'd1);
        end
        @(negedge clock);
        drive(1, 9, 32'h409, 0, 0, 0, 0);
        #1;
        chk("rst fill9 aluReady", 32'(aluReady), 32'd1);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 1);
        #1;
        chkPort("rst before", 1, 6'd6, 32'h406);
        chk("rst before pendingMask", pendingMask, 32'h3C0);
        #2;
        resetN = 1'b0;
        #1;
        chkPort("rst async", 0, 0, 32'h0);
        chk("rst async pendingMask", pendingMask, 32'h0);
        @(negedge clock);
        resetN = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            #1;
            chk($sformatf("post%0d regWrite", c), 32'(regWrite), 32'd0);
            chk($sformatf("post%0d pendingMask", c), pendingMask, 32'h0);
            chk($sformatf("post%0d aluReady", c), 32'(aluReady), 32'd1);
            chk($sformatf("post%0d memReady", c), 32'(memReady), 32'd1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
Write-side initiator for the processor register file. Accepts writeback results from two producers, the ALU path and the load/memory path, over valid/ready handshakes. Queues them in order in a small FIFO and drives the register file write port (writeRegister, writeData, regWrite) from registered outputs, at most one write per cycle. Exports a pending-write mask so decode can stall on read-after-write hazards.

Parameters:
DATA_WIDTH, 32, width of writeback data
ADDR_WIDTH, 6, width of register address (matches register file port)
NUM_REGS, 32, number of architectural registers; addresses >= NUM_REGS are invalid
FIFO_DEPTH, 4, writeback queue entries (power of two, >= 2)

Ports:
clock  input  1  single system clock, rising edge
resetN  input  1  asynchronous active-low reset
aluValid  input  1  ALU result offered
aluReady  output  1  ALU result accepted this edge when aluValid=1
aluRd  input  ADDR_WIDTH  ALU destination register
aluData  input  DATA_WIDTH  ALU result
memValid  input  1  load result offered
memReady  output  1  load result accepted this edge when memValid=1
memRd  input  ADDR_WIDTH  load destination register
memData  input  DATA_WIDTH  load result
wbStall  input  1  freeze retirement (register file port unavailable)
writeRegister  output  ADDR_WIDTH  register file write address
writeData  output  DATA_WIDTH  register file write data
regWrite  output  1  register file write enable, high for exactly one cycle per retired write
pendingMask  output  NUM_REGS  bit i=1 while any queued or in-flight write targets register i

Behaviour:
- Reset (resetN=0, async): FIFO emptied (count=0, pointers 0), writeRegister=0, writeData=0, regWrite=0, pendingMask=0, round-robin pointer = MEM. Register file contents are not touched.
- Clock and reset port names are fixed: clock, resetN. Reset is asynchronous and active-low.
- All three register-file outputs come straight from flops, so they are glitch-free. The register file is sensitive to writeClock changes, so no combinational path may drive them.
- full = (count == FIFO_DEPTH), evaluated from the registered count. A pop in the same cycle does not free a slot.
- Arbitration: aluReady = !full && (!memValid || rr==ALU); memReady = !full && (!aluValid || rr==MEM). At most one enqueue per edge.
- After any accepted transfer from source S, rr points to the other source. A lone requester therefore gets back-to-back grants.
- Enqueue stores {rd, data} at the tail. All entries are enqueued, including rd=0 and rd>=NUM_REGS, to preserve order.
- Retire: at each edge with wbStall=0 and count>0, the head pops into the output registers. regWrite<=1 only if 0 < rd < NUM_REGS, otherwise regWrite<=0 (discarded, slot consumed).
- With no pop at an edge, regWrite<=0 and writeRegister/writeData hold their values.
- Latency: a result accepted at edge k into an empty queue, with wbStall=0, is popped at edge k+1. regWrite is high from edge k+1 to k+2. Throughput is 1 write/cycle.
- Simultaneous enqueue and pop in the same edge: count is unchanged and both pointers advance.
- Pointer wrap: modulo FIFO_DEPTH.
- pendingMask is combinational from flops: OR over valid FIFO entries with valid rd, plus the output stage while regWrite=1. Bit 0 is always 0. Multiple queued writes to the same register keep the bit set until the last one retires.
- wbStall asserted with queue contents: nothing is lost. Ordering is strict FIFO across both sources.

Test Plan:
1. Single ALU write: aluValid=1, aluRd=5, aluData=0x12345678, queue empty -> aluReady=1; next cycle regWrite=1 for one cycle, writeRegister=5, writeData=0x12345678; pendingMask[5]=1 from accept until regWrite drops.
2. Contention: aluValid and memValid held high with distinct rd (alu 1,2,3 / mem 10,11,12) -> grants alternate MEM, ALU, MEM, ALU, ...; retired order 10,1,11,2,12,3.
3. Backpressure: wbStall=1, stream of 5 ALU writes (rd 1..5) -> first 4 accepted, aluReady=0 on the 5th with count=4. Release wbStall -> writes rd 1..4 on consecutive cycles, rd 5 accepted and written after them. No drops, no duplicates.
4. Invalid targets: ALU rd=0 data 0xFFFFFFFF, then mem rd=40 -> both accepted; regWrite stays 0; pendingMask stays 0.
5. Same-register ordering: mem rd=7 0x0000000A, then alu rd=7 0x0000000B -> writes occur in that order; pendingMask[7]=1 until the 0xB write cycle ends.
6. Reset mid-stream: wbStall=1 with 3 entries queued, pull resetN low between edges -> regWrite, writeRegister, writeData and pendingMask go to 0 immediately. After release, no stale writes appear and aluReady=memReady=1.
